// File: rtl/exu_div_issue_if.sv
// Decode-side request and integer-writeback handshake bundle for the divide issue controller.
// The master modport is the decode/writeback side and the slave modport is the issue controller.
interface exu_div_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        req_unsign;
  logic        req_rem;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_unsign, req_rem, req_rd, wb_ready,
    input  req_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_unsign, req_rem, req_rd, wb_ready,
    output req_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/exu_div_issue.sv
// Issue/writeback controller for the iterative divider: launches one op at a time,
// resolves divide-by-zero and signed overflow locally, and holds the result for writeback.
module exu_div_issue #(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  exu_div_issue_if.slave     io,
  input  logic               flush,
  output logic               div_valid,
  output logic               div_unsign,
  output logic               div_rem,
  output logic [31:0]        div_dividend,
  output logic [31:0]        div_divisor,
  output logic               div_flush,
  input  logic               div_finish,
  input  logic               div_finish_early,
  input  logic               div_stall,
  input  logic [31:0]        div_out,
  output logic               busy,
  output logic [4:0]         busy_rd
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, EARLY, WB} state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic        accept;
  logic        div_by_zero;
  logic        overflow;
  logic [31:0] special_result;

  assign io.req_ready = (state == IDLE) & ~div_stall & ~flush & ~rst;
  assign accept       = io.req_valid & io.req_ready;

  assign div_by_zero = FAST_SPECIAL && (io.req_rs2 == 32'd0);
  assign overflow    = FAST_SPECIAL && !io.req_unsign &&
                       (io.req_rs1 == 32'h8000_0000) && (io.req_rs2 == 32'hFFFF_FFFF);

  // Architectural results for the cases that never reach the divider.
  assign special_result = div_by_zero ? (io.req_rem ? io.req_rs1 : 32'hFFFF_FFFF)
                                      : (io.req_rem ? 32'd0 : 32'h8000_0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_q         <= '0;
      div_valid    <= 1'b0;
      div_unsign   <= 1'b0;
      div_rem      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_flush    <= 1'b0;
      io.wb_valid  <= 1'b0;
      io.wb_rd     <= '0;
      io.wb_data   <= '0;
      busy         <= 1'b0;
      busy_rd      <= '0;
    end else begin
      div_valid    <= 1'b0;
      div_unsign   <= 1'b0;
      div_rem      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      // Only the divider needs cancelling, so EARLY/WB flushes stay local.
      div_flush    <= flush & ((state == LAUNCH) | (state == RUN));

      if (flush) begin
        state       <= IDLE;
        io.wb_valid <= 1'b0;
        io.wb_rd    <= '0;
        io.wb_data  <= '0;
        busy        <= 1'b0;
        busy_rd     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && (io.req_rd != 5'd0)) begin
              rd_q    <= io.req_rd;
              busy    <= 1'b1;
              busy_rd <= io.req_rd;
              if (div_by_zero || overflow) begin
                state       <= WB;
                io.wb_valid <= 1'b1;
                io.wb_rd    <= io.req_rd;
                io.wb_data  <= special_result;
              end else begin
                state        <= LAUNCH;
                div_valid    <= 1'b1;
                div_unsign   <= io.req_unsign;
                div_rem      <= io.req_rem;
                div_dividend <= io.req_rs1;
                div_divisor  <= io.req_rs2;
              end
            end
          end
          LAUNCH: state <= RUN;
          RUN: begin
            if (div_finish) begin
              if (div_finish_early) begin
                state <= EARLY;
              end else begin
                state       <= WB;
                io.wb_valid <= 1'b1;
                io.wb_rd    <= rd_q;
                io.wb_data  <= div_out;
              end
            end
          end
          // Small-number results appear on div_out one cycle after the finish strobe.
          EARLY: begin
            state       <= WB;
            io.wb_valid <= 1'b1;
            io.wb_rd    <= rd_q;
            io.wb_data  <= div_out;
          end
          WB: begin
            if (io.wb_ready) begin
              state       <= IDLE;
              io.wb_valid <= 1'b0;
              io.wb_rd    <= '0;
              io.wb_data  <= '0;
              busy        <= 1'b0;
              busy_rd     <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
